// File: rtl/bp_resolve_queue.sv
// In-order tracker of predicted branches: pops on resolve, trains the 2-bit
// predictor, flags mispredicts, squashes wrong-path entries and keeps statistics.
module bp_resolve_queue #(
  parameter int IDX_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_pred,
  output logic             full,
  output logic             empty,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic             flush,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_actual,
  output logic             mispredict,
  output logic             resolve_err,
  output logic             overflow,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  entry_t head;
  logic   pop, miss, clr, push_ok, drop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Resolve is evaluated first; a clear (mispredict or flush) then kills any push.
  assign pop     = resolve_valid & ~empty;
  assign miss    = pop & (head.pred != resolve_taken);
  assign clr     = miss | flush;
  assign push_ok = push & (~full | pop) & ~clr;
  assign drop    = push & full & ~pop & ~clr;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop);
    end
  end

  // When full with a same-cycle pop, wr_ptr equals rd_ptr: head is read before the slot is rewritten.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{idx: push_idx, pred: push_pred};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      upd_en      <= 1'b0;
      upd_idx     <= '0;
      upd_actual  <= 1'b0;
      mispredict  <= 1'b0;
      resolve_err <= 1'b0;
      overflow    <= 1'b0;
      br_count    <= '0;
      miss_count  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      upd_en      <= pop;
      mispredict  <= miss;
      resolve_err <= resolve_valid & empty;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        upd_idx    <= head.idx;
        upd_actual <= resolve_taken;
        br_count   <= br_count + CNT_W'(1);
        if (miss) miss_count <= miss_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_bp_resolve_queue.sv
// Scoreboard bench for bp_resolve_queue; CNT_W=4 so the counter wrap is reachable.
module tb_bp_resolve_queue;
  logic       clk = 1'b0;
  logic       rst_n, push, push_pred, resolve_valid, resolve_taken, flush;
  logic [7:0] push_idx;
  logic       full, empty, upd_en, upd_actual, mispredict, resolve_err, overflow;
  logic [7:0] upd_idx;
  logic [3:0] br_count, miss_count;

  bp_resolve_queue #(.IDX_W(8), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_idx(push_idx), .push_pred(push_pred),
    .full(full), .empty(empty), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .flush(flush), .upd_en(upd_en), .upd_idx(upd_idx), .upd_actual(upd_actual),
    .mispredict(mispredict), .resolve_err(resolve_err), .overflow(overflow),
    .br_count(br_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] idx; logic pred; } ent_t;
  typedef struct { logic [7:0] idx; logic act; logic mis; } exp_t;

  ent_t       mq[$];
  exp_t       exp_q[$];
  exp_t       e;
  int         nc = 0, nf = 0;
  logic       m_upd_en = 0, m_err = 0, m_mis = 0, m_ovf = 0;
  logic [3:0] m_br = 0, m_miss = 0;

  // Drive one cycle and advance the reference model; outputs are sampled 1ns after the edge.
  task automatic step(input logic p, input logic [7:0] idx, input logic pr,
                      input logic rv, input logic tk, input logic fl);
    int sz;
    bit mpop, mmiss, mclr;
    push = p; push_idx = idx; push_pred = pr;
    resolve_valid = rv; resolve_taken = tk; flush = fl;
    sz    = mq.size();
    mpop  = rv && sz > 0;
    mmiss = mpop && (mq[0].pred != tk);
    mclr  = mmiss || fl;
    m_upd_en = mpop; m_err = rv && sz == 0; m_mis = mmiss;
    if (mpop) begin
      exp_q.push_back('{idx: mq[0].idx, act: tk, mis: mmiss});
      m_br++;
      if (mmiss) m_miss++;
      void'(mq.pop_front());
    end
    if (p && sz == 4 && !mpop && !mclr) m_ovf = 1'b1;
    if (mclr) mq.delete();
    else if (p && (sz < 4 || mpop)) mq.push_back('{idx: idx, pred: pr});
    @(posedge clk); #1;
    push = 0; resolve_valid = 0; flush = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; push = 0; push_idx = 0; push_pred = 0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;
    #12;
    nc++;
    if ({full, empty, upd_en, upd_idx, upd_actual, mispredict, resolve_err, overflow, br_count, miss_count}
        !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0}) begin
      nf++; $display("FAIL reset_outputs: full=%b empty=%b upd_en=%b idx=%h act=%b mis=%b err=%b ovf=%b br=%0d miss=%0d",
        full, empty, upd_en, upd_idx, upd_actual, mispredict, resolve_err, overflow, br_count, miss_count);
    end
    @(posedge clk); #1; rst_n = 1;
    step(0, 0, 0, 1, 1, 0);
    nc++;
    if ({resolve_err, upd_en, br_count} !== {1'b1, 1'b0, 4'h0}) begin
      nf++; $display("FAIL empty_resolve: err=%b upd_en=%b br=%0d, want 1 0 0", resolve_err, upd_en, br_count);
    end
    step(0, 0, 0, 0, 0, 0);
    nc++;
    if (resolve_err !== 1'b0) begin nf++; $display("FAIL err_pulse_width: err=%b want 0", resolve_err); end
  endtask

  task automatic test_correct;
    step(1, 8'h12, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    e = exp_q.pop_front();
    nc++;
    if ({upd_en, upd_idx, upd_actual, mispredict} !== {1'b1, e.idx, e.act, e.mis} || e.idx !== 8'h12) begin
      nf++; $display("FAIL correct_upd: en=%b idx=%h act=%b mis=%b want 1 %h %b %b", upd_en, upd_idx, upd_actual, mispredict, e.idx, e.act, e.mis);
    end
    nc++;
    if ({br_count, miss_count} !== {4'd1, 4'd0}) begin
      nf++; $display("FAIL correct_cnt: br=%0d miss=%0d want 1 0", br_count, miss_count);
    end
    step(0, 0, 0, 0, 0, 0);
    nc++;
    if (upd_en !== 1'b0) begin nf++; $display("FAIL upd_pulse_width: upd_en=%b want 0", upd_en); end
  endtask

  task automatic test_mispredict;
    step(1, 8'h01, 0, 0, 0, 0);
    step(1, 8'h02, 1, 0, 0, 0);
    step(1, 8'h03, 1, 0, 0, 0);
    step(1, 8'h04, 1, 1, 1, 0);
    e = exp_q.pop_front();
    nc++;
    if ({upd_en, upd_idx, upd_actual, mispredict} !== {1'b1, e.idx, e.act, e.mis} || !mispredict || upd_idx !== 8'h01) begin
      nf++; $display("FAIL mispredict_upd: en=%b idx=%h act=%b mis=%b want 1 01 1 1", upd_en, upd_idx, upd_actual, mispredict);
    end
    nc++;
    if ({empty, miss_count, overflow} !== {1'b1, m_miss, m_ovf}) begin
      nf++; $display("FAIL mispredict_clear: empty=%b miss=%0d ovf=%b want 1 %0d %b", empty, miss_count, overflow, m_miss, m_ovf);
    end
    step(0, 0, 0, 1, 0, 0);
    nc++;
    if ({resolve_err, upd_en, mispredict} !== {1'b1, 1'b0, 1'b0}) begin
      nf++; $display("FAIL post_flush_resolve: err=%b upd_en=%b mis=%b want 1 0 0", resolve_err, upd_en, mispredict);
    end
  endtask

  task automatic test_full_wrap;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h20 + 8'(i), 1, 0, 0, 0);
      if (i == 3) begin
        nc++;
        if ({full, overflow} !== {1'b1, 1'b0}) begin nf++; $display("FAIL full_at_4: full=%b ovf=%b want 1 0", full, overflow); end
      end
    end
    nc++;
    if ({full, overflow} !== {1'b1, 1'b1}) begin nf++; $display("FAIL overflow_5th: full=%b ovf=%b want 1 1", full, overflow); end
    step(1, 8'h25, 1, 1, 1, 0);
    e = exp_q.pop_front();
    nc++;
    if ({full, upd_en, upd_idx, mispredict} !== {1'b1, 1'b1, e.idx, 1'b0}) begin
      nf++; $display("FAIL push_pop_full: full=%b en=%b idx=%h mis=%b want 1 1 %h 0", full, upd_en, upd_idx, mispredict, e.idx);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 1, 0);
      e = exp_q.pop_front();
      nc++;
      if ({upd_en, upd_idx, upd_actual, mispredict} !== {1'b1, e.idx, e.act, e.mis}) begin
        nf++; $display("FAIL drain_order[%0d]: en=%b idx=%h act=%b mis=%b want 1 %h %b %b", i, upd_en, upd_idx, upd_actual, mispredict, e.idx, e.act, e.mis);
      end
    end
    nc++;
    if ({empty, full, br_count} !== {1'b1, 1'b0, m_br}) begin
      nf++; $display("FAIL drain_end: empty=%b full=%b br=%0d want 1 0 %0d", empty, full, br_count, m_br);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 0, 0, 0, 0);
    step(1, 8'h33, 0, 1, 0, 1);
    e = exp_q.pop_front();
    nc++;
    if ({upd_en, upd_idx, upd_actual, mispredict, empty} !== {1'b1, e.idx, e.act, 1'b0, 1'b1} || upd_idx !== 8'h30) begin
      nf++; $display("FAIL flush_resolve: en=%b idx=%h act=%b mis=%b empty=%b want 1 30 0 0 1", upd_en, upd_idx, upd_actual, mispredict, empty);
    end
    step(0, 0, 0, 0, 0, 0);
    nc++;
    if ({upd_en, empty, br_count, miss_count} !== {1'b0, 1'b1, m_br, m_miss}) begin
      nf++; $display("FAIL flush_after: en=%b empty=%b br=%0d miss=%0d want 0 1 %0d %0d", upd_en, empty, br_count, miss_count, m_br, m_miss);
    end
  endtask

  task automatic test_counter_wrap;
    logic [3:0] b0, m0;
    b0 = m_br; m0 = m_miss;
    for (int i = 0; i < 17; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      e = exp_q.pop_front();
      nc++;
      if ({upd_en, upd_idx, mispredict} !== {1'b1, e.idx, 1'b1}) begin
        nf++; $display("FAIL wrap_resolve[%0d]: en=%b idx=%h mis=%b want 1 %h 1", i, upd_en, upd_idx, mispredict, e.idx);
      end
    end
    nc++;
    if ({br_count, miss_count} !== {b0 + 4'd1, m0 + 4'd1}) begin
      nf++; $display("FAIL counter_wrap: br=%0d miss=%0d want %0d %0d", br_count, miss_count, b0 + 4'd1, m0 + 4'd1);
    end
  endtask

  task automatic test_back_to_back;
    step(1, 8'h41, 1, 0, 0, 0);
    step(1, 8'h42, 0, 0, 0, 0);
    step(1, 8'h43, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(0, 0, 0, 1, (i == 1) ? 1'b0 : 1'b1, 0);
      e = exp_q.pop_front();
      nc++;
      if ({upd_en, upd_idx, upd_actual, mispredict} !== {1'b1, e.idx, e.act, e.mis}) begin
        nf++; $display("FAIL b2b[%0d]: en=%b idx=%h act=%b mis=%b want 1 %h %b %b", i, upd_en, upd_idx, upd_actual, mispredict, e.idx, e.act, e.mis);
      end
    end
    nc++;
    if ({empty, br_count, miss_count, overflow} !== {1'b1, m_br, m_miss, m_ovf}) begin
      nf++; $display("FAIL b2b_end: empty=%b br=%0d miss=%0d ovf=%b want 1 %0d %0d %b", empty, br_count, miss_count, overflow, m_br, m_miss, m_ovf);
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_mispredict;
    test_full_wrap;
    test_flush;
    test_counter_wrap;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule

// File: doc/bp_resolve_queue.md
# bp_resolve_queue

Branch resolution tracker; the consumer end of the 2-bit branch predictor.
- Fetch pushes each predicted branch (table index + predicted direction) into an in-order queue.
- Execute reports the actual outcome; the block pops the oldest entry and compares it with the outcome.
- It drives the predictor's update interface (enable, index, actual outcome).
- It raises a one-cycle mispredict pulse, discards wrong-path entries, and keeps branch and mispredict statistics.

## Interface
Parameters:
- IDX_W, 8, predictor table index width
- DEPTH, 4, queue entries; power of two, ≥2
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- push  in  1  fetch issues a predicted branch this cycle
- push_idx  in  IDX_W  predictor index of pushed branch
- push_pred  in  1  predicted direction (1 = taken)
- full  out  1  queue holds DEPTH entries (combinational from count)
- empty  out  1  queue holds 0 entries
- resolve_valid  in  1  execute resolves oldest branch this cycle
- resolve_taken  in  1  actual direction
- flush  in  1  external pipeline flush (exception/redirect)
- upd_en  out  1  predictor update strobe (registered)
- upd_idx  out  IDX_W  index to update (registered)
- upd_actual  out  1  actual outcome to train (registered)
- mispredict  out  1  one-cycle pulse (registered)
- resolve_err  out  1  one-cycle pulse: resolve while empty
- overflow  out  1  sticky: push dropped while full
- br_count  out  CNT_W  branches resolved, wraps
- miss_count  out  CNT_W  mispredicts, wraps

## Operation
Queue:
- Circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
- Pointers wrap modulo DEPTH.

Push:
- Accepted when push=1 and either the queue is not full, or resolve_valid pops in the same cycle.
- A push while full with no pop is dropped and sets overflow.

Resolve:
- With resolve_valid=1 and the queue not empty, pop the head entry {idx, pred}.
- Next cycle: upd_en=1, upd_idx=idx, upd_actual=resolve_taken.
- mispredict=(pred≠resolve_taken).
- br_count increments by 1; miss_count increments by 1 on a mispredict. Both counters wrap to 0 after 2^CNT_W−1.

Mispredict:
- All entries younger than the popped one are wrong-path.
- The queue clears (count=0, rd_ptr=wr_ptr) in the same edge as the pop.
- A push in that same cycle is discarded and does not set overflow.

Resolve while empty:
- No pop, no update, no counter change.
- resolve_err pulses for one cycle.

flush=1:
- Queue clears and any same-cycle push is discarded.
- A same-cycle valid resolve is still processed first: update, counters and mispredict are produced normally, then the queue is cleared.

Priority within one edge: resolve/pop, then clear (mispredict or flush), then push.

Reset (rst_n=0, asynchronous, no clock needed):
- full=0, empty=1.
- upd_en=0, upd_idx=0, upd_actual=0.
- mispredict=0, resolve_err=0, overflow=0.
- br_count=0, miss_count=0.
- Pointers and count = 0.
- Queue contents are don't-care.
- Reset released mid-operation restarts from the empty state; no update is emitted for branches lost to reset.

## Timing
- Push to earliest resolvable: the next cycle. An entry written at edge N is the head from N onward.
- Resolve to upd_en/mispredict: 1 cycle latency. Outputs are high for exactly one cycle per resolve.
- Back-to-back resolves every cycle are supported, giving one update per cycle.
- upd_* is held stable for the whole cycle after the posedge, so a negedge-sampled predictor captures it safely.
- full/empty reflect the state after the last edge. Fetch must sample full before asserting push; the block tolerates violations via drop + overflow.
- Counters update on the same edge that registers upd_en.

## Test plan
- Reset and empty resolve: hold rst_n=0 and check every output equals its reset value. Release reset, then resolve_valid=1 while empty: resolve_err=1 for 1 cycle, upd_en=0, br_count=0.
- Correct prediction: push idx=0x12 pred=1, then resolve taken=1. Next cycle upd_en=1, upd_idx=0x12, upd_actual=1, mispredict=0, br_count=1, miss_count=0.
- Mispredict flush: push idx 0x01(pred 0), 0x02, 0x03, then resolve taken=1 alongside a push of 0x04. Expect mispredict=1, upd_idx=0x01, empty=1 next cycle, miss_count=1, and a subsequent resolve raises resolve_err.
- Full/overflow and wrap: with DEPTH=4, push 5 entries with no resolves: full=1 after 4, overflow=1 after the 5th. Then push and resolve simultaneously while full: push accepted, count stays 4. Drain 4 resolves and check that upd_idx order matches push order across pointer wrap.
- External flush with resolve: queue holds 3 entries; flush=1 with resolve_valid=1 and taken equal to pred. Expect one upd_en for the head, mispredict=0, empty=1 after the edge.
- Counter wrap: with CNT_W=4, perform 17 resolves, all mispredicted (refill the queue each time). Expect br_count=1 and miss_count=1.
